// File: rtl/uc_jogo_principal_if.sv
// Handshake bundle between the main game control unit and its environment:
// player-move inputs, sub-machine start/done signals, lives pulses and status.
interface uc_jogo_principal_param_if #(
  parameter int LARGURA_VIDAS = 3
);
  logic                     iniciar;
  logic                     pausar;
  logic                     ocorreu_jogada;
  logic                     ocorreu_tiro;
  logic                     fim_movimentacao;
  logic                     fim_registra_tiros;
  logic                     perda_vida;
  logic                     ganho_vida;
  logic                     enable_reg_jogada;
  logic                     reset_reg_jogada;
  logic                     inicia_movimentacao;
  logic                     inicia_registra_tiros;
  logic                     reset_contadores;
  logic                     reset_maquinas;
  logic                     pronto;
  logic                     pausado;
  logic                     erro;
  logic [LARGURA_VIDAS-1:0] vidas;
  logic [3:0]               db_estado;

  modport master (
    output iniciar, pausar, ocorreu_jogada, ocorreu_tiro,
           fim_movimentacao, fim_registra_tiros, perda_vida, ganho_vida,
    input  enable_reg_jogada, reset_reg_jogada, inicia_movimentacao,
           inicia_registra_tiros, reset_contadores, reset_maquinas,
           pronto, pausado, erro, vidas, db_estado
  );

  modport slave (
    input  iniciar, pausar, ocorreu_jogada, ocorreu_tiro,
           fim_movimentacao, fim_registra_tiros, perda_vida, ganho_vida,
    output enable_reg_jogada, reset_reg_jogada, inicia_movimentacao,
           inicia_registra_tiros, reset_contadores, reset_maquinas,
           pronto, pausado, erro, vidas, db_estado
  );
endinterface

// File: rtl/uc_jogo_principal_param.sv
// Main game control unit: sequences moves, asteroid/shot movement and shot
// registration, with lives counter, idle auto-tick, pause and sub-machine watchdog.
module uc_jogo_principal_param #(
  parameter int VIDAS_INICIAIS = 3,
  parameter int VIDAS_MAX      = 7,
  parameter int LARGURA_VIDAS  = 3,
  parameter int TIMEOUT_JOGADA = 1000,
  parameter int SALVA_CICLOS   = 2,
  parameter int WATCHDOG       = 4096
) (
  input logic clock,
  input logic reset_n,
  uc_jogo_principal_param_if.slave bus
);

  typedef enum logic [3:0] {
    INICIAL               = 4'h0,
    INICIALIZA            = 4'h1,
    ESPERA_JOGADA         = 4'h2,
    REGISTRA_JOGADA       = 4'h3,
    ESPERA_SALVAMENTO     = 4'h4,
    MOVIMENTA             = 4'h5,
    ESPERA_MOVIMENTACAO   = 4'h6,
    INICIA_REGISTRA_TIROS = 4'h7,
    ESPERA_REGISTRA_TIROS = 4'h8,
    PAUSA                 = 4'h9,
    FIM_JOGO              = 4'hA,
    ERRO                  = 4'hF
  } estado_t;

  localparam int TW      = (TIMEOUT_JOGADA > 1) ? $clog2(TIMEOUT_JOGADA) : 1;
  localparam int ESP_MAX = (WATCHDOG > SALVA_CICLOS) ? WATCHDOG : SALVA_CICLOS;
  localparam int CW      = (ESP_MAX > 1) ? $clog2(ESP_MAX) : 1;

  localparam logic [TW-1:0]            TIMER_FIM = TW'(TIMEOUT_JOGADA - 1);
  localparam logic [CW-1:0]            WD_FIM    = CW'(WATCHDOG - 1);
  localparam logic [CW-1:0]            SALVA_FIM = CW'(SALVA_CICLOS - 1);
  localparam logic [LARGURA_VIDAS-1:0] V_MAX     = LARGURA_VIDAS'(VIDAS_MAX);
  localparam logic [LARGURA_VIDAS-1:0] V_INI     = LARGURA_VIDAS'(VIDAS_INICIAIS);

  estado_t                  estado, prox;
  logic [TW-1:0]            timer;
  logic [CW-1:0]            cont;
  logic [LARGURA_VIDAS-1:0] vidas;
  logic                     tiro_pendente;
  logic                     timeout, wd_estouro, salva_ultimo, sem_vidas;

  assign timeout      = (TIMEOUT_JOGADA != 0) && (timer == TIMER_FIM);
  assign wd_estouro   = (WATCHDOG != 0) && (cont == WD_FIM);
  assign salva_ultimo = (cont == SALVA_FIM);
  assign sem_vidas    = (vidas == '0);

  always_ff @(posedge clock) begin
    if (!reset_n) estado <= INICIAL;
    else          estado <= prox;
  end

  // cont is shared: save-delay counter in ESPERA_SALVAMENTO, watchdog in the
  // two sub-machine waits; every path between those states passes a clearing state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      timer         <= '0;
      cont          <= '0;
      vidas         <= '0;
      tiro_pendente <= 1'b0;
    end else begin
      case (estado)
        ESPERA_JOGADA: timer <= timer + 1'b1;
        PAUSA:         timer <= timer;
        default:       timer <= '0;
      endcase

      case (estado)
        ESPERA_SALVAMENTO, ESPERA_MOVIMENTACAO, ESPERA_REGISTRA_TIROS:
                 cont <= cont + 1'b1;
        default: cont <= '0;
      endcase

      if (estado == INICIALIZA || estado == INICIA_REGISTRA_TIROS)
        tiro_pendente <= 1'b0;
      else if (estado == ESPERA_SALVAMENTO && salva_ultimo)
        tiro_pendente <= bus.ocorreu_tiro;

      case (estado)
        INICIALIZA:                 vidas <= V_INI;
        INICIAL, FIM_JOGO, ERRO:    vidas <= vidas;
        default: begin
          if (bus.perda_vida && !bus.ganho_vida && vidas != '0)
            vidas <= vidas - 1'b1;
          else if (bus.ganho_vida && !bus.perda_vida && vidas != V_MAX)
            vidas <= vidas + 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:         if (bus.iniciar) prox = INICIALIZA;
      INICIALIZA:      prox = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (sem_vidas)               prox = FIM_JOGO;
        else if (bus.pausar)         prox = PAUSA;
        else if (bus.ocorreu_jogada) prox = REGISTRA_JOGADA;
        else if (timeout)            prox = MOVIMENTA;
      end
      REGISTRA_JOGADA: prox = ESPERA_SALVAMENTO;
      ESPERA_SALVAMENTO: begin
        if (salva_ultimo) begin
          if (sem_vidas)             prox = FIM_JOGO;
          else if (bus.ocorreu_tiro) prox = MOVIMENTA;
          else                       prox = ESPERA_JOGADA;
        end
      end
      MOVIMENTA:       prox = ESPERA_MOVIMENTACAO;
      ESPERA_MOVIMENTACAO: begin
        if (bus.fim_movimentacao) begin
          if (sem_vidas)          prox = FIM_JOGO;
          else if (tiro_pendente) prox = INICIA_REGISTRA_TIROS;
          else                    prox = ESPERA_JOGADA;
        end else if (wd_estouro) prox = ERRO;
      end
      INICIA_REGISTRA_TIROS: prox = ESPERA_REGISTRA_TIROS;
      ESPERA_REGISTRA_TIROS: begin
        if (bus.fim_registra_tiros) prox = ESPERA_JOGADA;
        else if (wd_estouro)        prox = ERRO;
      end
      PAUSA:           if (!bus.pausar) prox = ESPERA_JOGADA;
      FIM_JOGO:        if (bus.iniciar) prox = INICIALIZA;
      ERRO:            prox = ERRO;
      default:         prox = ERRO;
    endcase
  end

  always_comb begin
    bus.enable_reg_jogada     = 1'b0;
    bus.reset_reg_jogada      = 1'b0;
    bus.inicia_movimentacao   = 1'b0;
    bus.inicia_registra_tiros = 1'b0;
    bus.reset_contadores      = 1'b0;
    bus.reset_maquinas        = 1'b0;
    bus.pronto                = 1'b0;
    bus.pausado               = 1'b0;
    bus.erro                  = 1'b0;
    case (estado)
      INICIALIZA, FIM_JOGO: begin
        bus.reset_reg_jogada = 1'b1;
        bus.reset_contadores = 1'b1;
        bus.reset_maquinas   = 1'b1;
        bus.pronto           = (estado == FIM_JOGO);
      end
      ESPERA_JOGADA:         bus.reset_reg_jogada      = 1'b1;
      REGISTRA_JOGADA:       bus.enable_reg_jogada     = 1'b1;
      MOVIMENTA:             bus.inicia_movimentacao   = 1'b1;
      INICIA_REGISTRA_TIROS: bus.inicia_registra_tiros = 1'b1;
      PAUSA:                 bus.pausado               = 1'b1;
      ERRO: begin
        bus.erro           = 1'b1;
        bus.reset_maquinas = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.vidas     = vidas;
  assign bus.db_estado = estado;

endmodule

// File: tb/tb_uc_jogo_principal_param.sv
// Directed bench for uc_jogo_principal_param with short timeout and watchdog.
module tb_uc_jogo_principal_param;
  logic clock = 1'b0;
  logic reset_n;
  int   n_testes = 0;
  int   n_falhas = 0;

  uc_jogo_principal_param_if #(.LARGURA_VIDAS(3)) bus ();

  uc_jogo_principal_param #(
    .VIDAS_INICIAIS(3), .VIDAS_MAX(7), .LARGURA_VIDAS(3),
    .TIMEOUT_JOGADA(8), .SALVA_CICLOS(2), .WATCHDOG(16)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic verifica(input string tag, input int obs, input int esp);
    n_testes++;
    if (obs !== esp) begin
      n_falhas++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int esp_pausa [1:12] = '{2, 2, 2, 2, 9, 9, 9, 2, 2, 2, 5, 6};

  initial begin
    reset_n                = 1'b0;
    bus.iniciar            = 1'b0;
    bus.pausar             = 1'b0;
    bus.ocorreu_jogada     = 1'b0;
    bus.ocorreu_tiro       = 1'b0;
    bus.fim_movimentacao   = 1'b0;
    bus.fim_registra_tiros = 1'b0;
    bus.perda_vida         = 1'b0;
    bus.ganho_vida         = 1'b0;
    tick(); tick();
    verifica("rst_estado", int'(bus.db_estado), 0);
    verifica("rst_vidas", int'(bus.vidas), 0);
    verifica("rst_pronto", int'(bus.pronto), 0);
    verifica("rst_rcont", int'(bus.reset_contadores), 0);
    verifica("rst_erro", int'(bus.erro), 0);

    // start
    reset_n = 1'b1;
    tick();
    verifica("ocioso", int'(bus.db_estado), 0);
    bus.iniciar = 1'b1;
    tick();
    verifica("inicializa", int'(bus.db_estado), 1);
    verifica("rcont_em_1", int'(bus.reset_contadores), 1);
    verifica("rmaq_em_1", int'(bus.reset_maquinas), 1);
    bus.iniciar = 1'b0;
    tick();
    verifica("espera", int'(bus.db_estado), 2);
    verifica("vidas_ini", int'(bus.vidas), 3);
    verifica("rcont_em_2", int'(bus.reset_contadores), 0);
    verifica("rreg_em_2", int'(bus.reset_reg_jogada), 1);

    // move with a shot
    bus.ocorreu_jogada = 1'b1;
    bus.ocorreu_tiro   = 1'b1;
    tick();
    verifica("registra", int'(bus.db_estado), 3);
    verifica("en_reg", int'(bus.enable_reg_jogada), 1);
    bus.ocorreu_jogada = 1'b0;
    tick();
    verifica("salva_a", int'(bus.db_estado), 4);
    verifica("en_reg_off", int'(bus.enable_reg_jogada), 0);
    tick();
    verifica("salva_b", int'(bus.db_estado), 4);
    tick();
    verifica("movimenta", int'(bus.db_estado), 5);
    verifica("ini_mov", int'(bus.inicia_movimentacao), 1);
    bus.ocorreu_tiro     = 1'b0;
    bus.fim_movimentacao = 1'b1;
    tick();
    verifica("esp_mov", int'(bus.db_estado), 6);
    verifica("ini_mov_off", int'(bus.inicia_movimentacao), 0);
    bus.fim_movimentacao = 1'b0;
    tick(); tick(); tick(); tick();
    verifica("esp_mov_p5", int'(bus.db_estado), 6);
    bus.fim_movimentacao = 1'b1;
    tick();
    verifica("ini_reg_est", int'(bus.db_estado), 7);
    verifica("ini_reg", int'(bus.inicia_registra_tiros), 1);
    bus.fim_movimentacao = 1'b0;
    tick();
    verifica("esp_reg", int'(bus.db_estado), 8);
    verifica("ini_reg_off", int'(bus.inicia_registra_tiros), 0);
    bus.fim_registra_tiros = 1'b1;
    tick();
    verifica("volta_esp", int'(bus.db_estado), 2);
    bus.fim_registra_tiros = 1'b0;

    // idle auto-tick with a 3-cycle pause at timer=4
    for (int i = 1; i <= 12; i++) begin
      tick();
      verifica($sformatf("pausa_c%0d", i), int'(bus.db_estado), esp_pausa[i]);
      if (i == 5) verifica("pausado", int'(bus.pausado), 1);
      if (i == 4) bus.pausar = 1'b1;
      if (i == 7) bus.pausar = 1'b0;
    end
    bus.fim_movimentacao = 1'b1;
    tick();
    verifica("sem_tiro", int'(bus.db_estado), 2);
    bus.fim_movimentacao = 1'b0;

    // lose all lives, then restart
    bus.perda_vida = 1'b1;
    tick(); verifica("vidas_2", int'(bus.vidas), 2);
    tick(); verifica("vidas_1", int'(bus.vidas), 1);
    tick(); verifica("vidas_0", int'(bus.vidas), 0);
    tick();
    verifica("fim_jogo", int'(bus.db_estado), 10);
    verifica("pronto", int'(bus.pronto), 1);
    verifica("perda_em_0", int'(bus.vidas), 0);
    bus.perda_vida = 1'b0;
    bus.iniciar    = 1'b1;
    tick();
    verifica("reinicia", int'(bus.db_estado), 1);
    bus.iniciar = 1'b0;
    tick();
    verifica("reinicia_esp", int'(bus.db_estado), 2);
    verifica("reinicia_vidas", int'(bus.vidas), 3);

    // saturation at VIDAS_MAX
    bus.ganho_vida = 1'b1;
    tick(); tick(); tick(); tick();
    verifica("vidas_7", int'(bus.vidas), 7);
    tick();
    verifica("ganho_em_7", int'(bus.vidas), 7);
    bus.perda_vida = 1'b1;
    tick();
    verifica("ambos_em_7", int'(bus.vidas), 7);
    bus.perda_vida = 1'b0;
    bus.ganho_vida = 1'b0;
    tick();
    verifica("timeout_pre", int'(bus.db_estado), 2);
    tick();
    verifica("timeout_mov", int'(bus.db_estado), 5);

    // watchdog: fim_movimentacao never arrives
    tick();
    verifica("wd_inicio", int'(bus.db_estado), 6);
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 15) verifica("wd_c15", int'(bus.db_estado), 6);
    end
    tick();
    verifica("erro_est", int'(bus.db_estado), 15);
    verifica("erro", int'(bus.erro), 1);
    verifica("erro_rmaq", int'(bus.reset_maquinas), 1);
    tick();
    verifica("erro_preso", int'(bus.db_estado), 15);
    reset_n = 1'b0;
    tick();
    verifica("rst_erro_est", int'(bus.db_estado), 0);
    verifica("rst_erro_vidas", int'(bus.vidas), 0);
    verifica("rst_erro_flag", int'(bus.erro), 0);

    $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
    $finish;
  end
endmodule
